// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared widths, RV32I opcode/funct3 constants and pipe FSM encodings.
package pipe_ctrl_pkg;
   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;
   localparam int RegAddrBus  = 5;
   localparam logic [InstBus-1:0] ZeroWord = 32'h0;
   localparam logic [6:0] INST_TYPE_L   = 7'b0000011;
   localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
   localparam logic [6:0] INST_TYPE_S   = 7'b0100011;
   localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
   localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
   localparam logic [6:0] INST_JALR     = 7'b1100111;
   localparam logic [6:0] INST_TYPE_CSR = 7'b1110011;
   localparam logic [2:0] INST_CSRRW    = 3'b001;
   localparam logic [2:0] INST_CSRRS    = 3'b010;
   localparam logic [2:0] INST_CSRRC    = 3'b011;
   typedef enum logic [1:0] {
      PIPE_RUN    = 2'd0,
      PIPE_DRAIN  = 2'd1,
      PIPE_HALTED = 2'd2
   } pipe_state_e;
endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// pipe_hazard_det: combinational load-use detection between decode and a load in execute.
module pipe_hazard_det
   import pipe_ctrl_pkg::*;
(
   input  logic [InstBus-1:0] id_inst_i,
   input  logic [InstBus-1:0] ex_inst_i,
   output logic               load_use_o
);
   logic [6:0]            id_op;
   logic [2:0]            id_f3;
   logic [RegAddrBus-1:0] rs1, rs2, ex_rd;
   logic                  rs1_use, rs2_use;
   logic                  unused_bits;
   assign unused_bits = ^{id_inst_i[31:25], id_inst_i[11:7], ex_inst_i[31:12]};
   always_comb begin
      id_op      = id_inst_i[6:0];
      id_f3      = id_inst_i[14:12];
      rs1        = id_inst_i[19:15];
      rs2        = id_inst_i[24:20];
      ex_rd      = ex_inst_i[11:7];
      rs2_use    = id_op inside {INST_TYPE_S, INST_TYPE_B, INST_TYPE_R_M};
      rs1_use    = rs2_use || (id_op inside {INST_TYPE_I, INST_TYPE_L, INST_JALR})
                   || (id_op == INST_TYPE_CSR && (id_f3 inside {INST_CSRRW, INST_CSRRS, INST_CSRRC}));
      load_use_o = ex_inst_i[6:0] == INST_TYPE_L && ex_rd != '0
                   && ((rs1_use && rs1 == ex_rd) || (rs2_use && rs2 == ex_rd));
   end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect sequencing with load-use stall, deferred jumps and debug drain/halt.
// Define PIPE_CTRL_PERF_EN to build the saturating stall-cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [InstBus-1:0]     id_inst_i,
   input  logic [InstBus-1:0]     ex_inst_i,
   input  logic                   ex_jump_flag_i,
   input  logic [InstAddrBus-1:0] ex_jump_addr_i,
   input  logic                   ex_hold_req_i,
   input  logic                   bus_hold_req_i,
   input  logic                   halt_req_i,
   output logic                   hold_pc_o,
   output logic                   hold_if_id_o,
   output logic                   hold_id_ex_o,
   output logic                   flush_if_id_o,
   output logic                   flush_id_ex_o,
   output logic                   jump_flag_o,
   output logic [InstAddrBus-1:0] jump_addr_o,
   output logic                   halt_ack_o,
   output logic [1:0]             state_o,
   output logic [31:0]            stall_cnt_o
);
   pipe_state_e            state_q, state_d;
   logic [1:0]             drain_cnt_q, drain_cnt_d;
   logic                   pend_valid_q, pend_valid_d;
   logic [InstAddrBus-1:0] pend_addr_q, pend_addr_d;
   logic                   halt_ack_q;
   logic                   hold, redirect, load_use;
   logic                   hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
   logic [InstAddrBus-1:0] jump_addr;

   pipe_hazard_det u_hazard (
      .id_inst_i  (id_inst_i),
      .ex_inst_i  (ex_inst_i),
      .load_use_o (load_use)
   );

   always_comb begin
      hold        = ex_hold_req_i | bus_hold_req_i;
      redirect    = ~hold & (pend_valid_q | ex_jump_flag_i);
      hold_pc     = 1'b0;
      hold_if_id  = 1'b0;
      hold_id_ex  = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      jump_addr   = redirect ? (pend_valid_q ? pend_addr_q : ex_jump_addr_i) : ZeroWord;
      if (hold) begin
         hold_pc    = 1'b1;
         hold_if_id = 1'b1;
         hold_id_ex = 1'b1;
      end else if (redirect) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (load_use || state_q != PIPE_RUN) begin
         hold_pc     = 1'b1;
         hold_if_id  = 1'b1;
         flush_id_ex = 1'b1;
      end
      // a redirect seen while held is re-latched every held cycle and replayed once hold drops
      pend_valid_d = hold & (pend_valid_q | ex_jump_flag_i);
      pend_addr_d  = (hold & ex_jump_flag_i) ? ex_jump_addr_i : pend_addr_q;
      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      case (state_q)
         PIPE_RUN: if (halt_req_i && !hold) begin
            state_d     = PIPE_DRAIN;
            drain_cnt_d = '0;
         end
         PIPE_DRAIN: if (!halt_req_i) state_d = PIPE_RUN;
            else if (!hold) begin
               drain_cnt_d = drain_cnt_q + 2'd1;
               state_d     = drain_cnt_q == 2'd1 ? PIPE_HALTED : PIPE_DRAIN;
            end
         PIPE_HALTED: if (!halt_req_i) state_d = PIPE_RUN;
         default: state_d = PIPE_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= PIPE_RUN;
         drain_cnt_q  <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= ZeroWord;
         halt_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_cnt_q  <= drain_cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         halt_ack_q   <= state_q == PIPE_HALTED;
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   assign stall_cnt_d = (hold_pc && state_q != PIPE_HALTED && stall_cnt_q != 32'hFFFF_FFFF)
                        ? stall_cnt_q + 32'd1 : stall_cnt_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end
   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = ZeroWord;
`endif

   // combinational outputs are forced quiet while reset is asserted
   assign hold_pc_o     = rst & hold_pc;
   assign hold_if_id_o  = rst & hold_if_id;
   assign hold_id_ex_o  = rst & hold_id_ex;
   assign flush_if_id_o = rst & flush_if_id;
   assign flush_id_ex_o = rst & flush_id_ex;
   assign jump_flag_o   = rst & redirect;
   assign jump_addr_o   = rst ? jump_addr : ZeroWord;
   assign halt_ack_o    = halt_ack_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model.
// Honors PIPE_CTRL_PERF_EN to pick the expected stall counter behaviour.
module tb_pipe_ctrl;
   logic        clk = 1'b0, rst = 1'b0;
   logic [31:0] id_inst_i, ex_inst_i, ex_jump_addr_i;
   logic        ex_jump_flag_i, ex_hold_req_i, bus_hold_req_i, halt_req_i;
   logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, flush_if_id_o, flush_id_ex_o, jump_flag_o, halt_ack_o;
   logic [31:0] jump_addr_o, stall_cnt_o;
   logic [1:0]  state_o;
   int          checks = 0, errors = 0;
   int          m_mode, m_drained;
   bit          m_pend, m_ack;
   logic [31:0] m_paddr, m_stall;
   logic        e_hpc, e_hif, e_hie, e_fif, e_fie, e_jf;
   logic [31:0] e_ja;
   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .id_inst_i(id_inst_i), .ex_inst_i(ex_inst_i),
      .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
      .ex_hold_req_i(ex_hold_req_i), .bus_hold_req_i(bus_hold_req_i), .halt_req_i(halt_req_i),
      .hold_pc_o(hold_pc_o), .hold_if_id_o(hold_if_id_o), .hold_id_ex_o(hold_id_ex_o),
      .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o), .jump_flag_o(jump_flag_o),
      .jump_addr_o(jump_addr_o), .halt_ack_o(halt_ack_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lw(logic [4:0] rd, logic [4:0] rs1);
      return {12'h0, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] add(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      return {7'h0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [9] = '{7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h67, 7'h73, 7'h37, 7'h6f};
      logic [31:0] r = $urandom;
      return {r[31:25], 3'b0, r[1:0], 3'b0, r[3:2], r[14:12], 3'b0, r[5:4], ops[$urandom_range(0, 8)]};
   endfunction
   function automatic bit reads(logic [31:0] inst, logic [4:0] r);
      logic [6:0] op = inst[6:0];
      bit u2 = op inside {7'h23, 7'h63, 7'h33};
      bit u1 = u2 || (op inside {7'h13, 7'h03, 7'h67}) || (op == 7'h73 && inst[14:12] inside {3'd1, 3'd2, 3'd3});
      return (u1 && inst[19:15] == r) || (u2 && inst[24:20] == r);
   endfunction
   function automatic bit load_use(logic [31:0] id, logic [31:0] ex);
      return ex[6:0] == 7'h03 && ex[11:7] != 5'd0 && reads(id, ex[11:7]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_drained = 0; m_pend = 0; m_ack = 0; m_paddr = '0; m_stall = '0;
   endtask

   task automatic expect_outputs();
      bit held = ex_hold_req_i | bus_hold_req_i;
      {e_hpc, e_hif, e_hie, e_fif, e_fie, e_jf} = '0;
      e_ja = '0;
      if (held) {e_hpc, e_hif, e_hie} = 3'b111;
      else if (m_pend || ex_jump_flag_i) begin
         {e_jf, e_fif, e_fie} = 3'b111;
         e_ja = m_pend ? m_paddr : ex_jump_addr_i;
      end else if (m_mode != 0 || load_use(id_inst_i, ex_inst_i)) {e_hpc, e_hif, e_fie} = 3'b111;
   endtask

   task automatic compare_all(string tag);
      chk({tag, ".hold_pc"}, 32'(hold_pc_o), 32'(e_hpc));
      chk({tag, ".hold_if_id"}, 32'(hold_if_id_o), 32'(e_hif));
      chk({tag, ".hold_id_ex"}, 32'(hold_id_ex_o), 32'(e_hie));
      chk({tag, ".flush_if_id"}, 32'(flush_if_id_o), 32'(e_fif));
      chk({tag, ".flush_id_ex"}, 32'(flush_id_ex_o), 32'(e_fie));
      chk({tag, ".jump_flag"}, 32'(jump_flag_o), 32'(e_jf));
      chk({tag, ".jump_addr"}, jump_addr_o, e_ja);
      chk({tag, ".state"}, 32'(state_o), 32'(m_mode));
      chk({tag, ".halt_ack"}, 32'(halt_ack_o), 32'(m_ack));
      chk({tag, ".stall_cnt"}, stall_cnt_o, PERF ? m_stall : 32'h0);
   endtask

   task automatic compare_zero(string tag);
      {e_hpc, e_hif, e_hie, e_fif, e_fie, e_jf} = '0;
      e_ja = '0;
      model_reset();
      compare_all(tag);
   endtask

   task automatic step(string tag);
      bit held;
      int prev;
      #3;
      expect_outputs();
      compare_all(tag);
      held = ex_hold_req_i | bus_hold_req_i;
      prev = m_mode;
      @(posedge clk);
      if (held && ex_jump_flag_i) begin m_pend = 1; m_paddr = ex_jump_addr_i; end
      else if (!held) m_pend = 0;
      if (prev == 0 && halt_req_i && !held) begin m_mode = 1; m_drained = 0; end
      else if (prev == 1 && !halt_req_i) m_mode = 0;
      else if (prev == 1 && !held) begin
         m_drained++;
         if (m_drained == 2) m_mode = 2;
      end else if (prev == 2 && !halt_req_i) m_mode = 0;
      m_ack = prev == 2;
      if (e_hpc && prev != 2 && m_stall != 32'hFFFF_FFFF) m_stall++;
      #1;
   endtask

   task automatic idle_inputs();
      id_inst_i = NOP; ex_inst_i = NOP; ex_jump_flag_i = 0; ex_jump_addr_i = '0;
      ex_hold_req_i = 0; bus_hold_req_i = 0; halt_req_i = 0;
   endtask

   initial begin
      idle_inputs();
      bus_hold_req_i = 1; ex_jump_flag_i = 1; ex_jump_addr_i = 32'h44; halt_req_i = 1;
      ex_inst_i = lw(5, 1); id_inst_i = add(6, 5, 2);
      #2 compare_zero("rst_low");
      @(posedge clk); #1;
      compare_zero("rst_low_edge");
      idle_inputs();
      model_reset();
      rst = 1;
      step("idle");
      ex_inst_i = lw(5, 1); id_inst_i = add(6, 5, 2);
      step("lu_stall");
      ex_inst_i = NOP;
      step("lu_bubble");
      ex_inst_i = lw(5, 1); id_inst_i = add(6, 0, 2);
      step("lu_x0_src");
      ex_inst_i = lw(0, 1); id_inst_i = add(6, 0, 0);
      step("lu_rd_x0");
      idle_inputs();
      ex_jump_flag_i = 1; ex_jump_addr_i = 32'h100;
      step("redirect");
      idle_inputs();
      bus_hold_req_i = 1; ex_jump_flag_i = 1; ex_jump_addr_i = 32'h200;
      step("defer_c1");
      ex_jump_flag_i = 0; ex_jump_addr_i = 32'h999;
      step("defer_c2");
      step("defer_c3");
      bus_hold_req_i = 0;
      #3 chk("defer_issue_addr", jump_addr_o, 32'h200);
      #0 step("defer_c4");
      idle_inputs();
      halt_req_i = 1;
      for (int i = 0; i < 5; i++) step("halt");
      halt_req_i = 0;
      for (int i = 0; i < 3; i++) step("unhalt");
      halt_req_i = 1;
      step("halt2_accept");
      step("halt2_drain");
      bus_hold_req_i = 1; ex_jump_flag_i = 1; ex_jump_addr_i = 32'h300;
      step("halt2_pend");
      rst = 0;
      #2 compare_zero("rst_mid_drain");
      @(posedge clk); #1;
      rst = 1;
      idle_inputs();
      step("post_rst");
      for (int i = 0; i < 5; i++) begin
         ex_inst_i = lw(5, 1); id_inst_i = add(6, 5, 2);
         step("perf_lu");
         ex_inst_i = NOP;
         step("perf_bubble");
      end
      bus_hold_req_i = 1;
      for (int i = 0; i < 3; i++) step("perf_hold");
      bus_hold_req_i = 0;
      #3 chk("perf_total", stall_cnt_o, PERF ? 32'd8 : 32'd0);
      #0 step("perf_after");
      for (int i = 0; i < 600; i++) begin
         ex_hold_req_i  = $urandom_range(0, 9) == 0;
         bus_hold_req_i = $urandom_range(0, 9) < 2;
         ex_jump_flag_i = $urandom_range(0, 7) == 0;
         ex_jump_addr_i = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 24) == 0) halt_req_i = ~halt_req_i;
         ex_inst_i = $urandom_range(0, 1) ? lw(5'($urandom_range(0, 3)), 5'd1) : rand_inst();
         id_inst_i = rand_inst();
         step("rnd");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
